// File: rtl/vga_timing_pkg.sv
// Default VGA 640x480@60 segment constants, derived totals/sync windows and sync polarity encoding.
package vga_timing_pkg;
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int H_SYNC_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
  localparam int V_SYNC_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  localparam sync_pol_e SYNC_POL_DEF = SYNC_ACTIVE_LOW;

  // Output pin level for a sync window flag under the given polarity.
  function automatic logic sync_level(input logic pol, input logic act);
    return act ? pol : ~pol;
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus: pixel enable in, position/decode/strobes out.
interface vga_timing_gen_if #(
  parameter int POS_W   = 10,
  parameter int FRAME_W = 8
);
  logic               pix_en;
  logic [POS_W-1:0]   hpos;
  logic [POS_W-1:0]   vpos;
  logic               visible;
  logic               hsync;
  logic               vsync;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    input  pix_en,
    output hpos, vpos, visible, hsync, vsync, line_start, frame_start, frame_cnt
  );

  modport slave (
    output pix_en,
    input  hpos, vpos, visible, hsync, vsync, line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_axis_counter.sv
// Generic wrap counter for one raster axis; exposes next-state decodes so the caller can register
// them in lock-step with the count.
module vga_axis_counter #(
  parameter int W      = 10,
  parameter int TOTAL  = 800,
  parameter int VIS    = 640,
  parameter int WIN_LO = 656,
  parameter int WIN_HI = 751
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic         wrap,
  output logic [W-1:0] count,
  output logic         nxt_vis,
  output logic         nxt_win
);
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);
  localparam logic [W-1:0] VIS_C = W'(VIS);
  localparam logic [W-1:0] LO_C  = W'(WIN_LO);
  localparam logic [W-1:0] HI_C  = W'(WIN_HI);

  logic [W-1:0] nxt;

  assign wrap = en && (count == LAST);

  // Compare against LAST explicitly; TOTAL need not be a power of two.
  always_comb begin
    nxt = count;
    if (en) nxt = (count == LAST) ? '0 : count + 1'b1;
  end

  assign nxt_vis = (nxt < VIS_C);
  assign nxt_win = (nxt >= LO_C) && (nxt <= HI_C);

  always_ff @(posedge clk) begin
    if (!rst_n) count <= LAST;
    else        count <= nxt;
  end
endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: hpos/vpos, visible, syncs, line/frame strobes, all registered together.
// Optional completed-frame counter built only when VGA_FRAME_COUNTER_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter bit SYNC_POL  = SYNC_POL_DEF,
  parameter int POS_W     = 10,
  parameter int FRAME_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SS    = H_VISIBLE + H_FRONT;
  localparam int V_SS    = V_VISIBLE + V_FRONT;

  logic h_wrap, v_wrap, v_en;
  logic h_vis_nxt, v_vis_nxt, h_sync_nxt, v_sync_nxt;

  assign v_en = vga.pix_en & h_wrap;

  vga_axis_counter #(
    .W(POS_W), .TOTAL(H_TOTAL), .VIS(H_VISIBLE), .WIN_LO(H_SS), .WIN_HI(H_SS + H_SYNC - 1)
  ) u_h (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (vga.pix_en),
    .wrap    (h_wrap),
    .count   (vga.hpos),
    .nxt_vis (h_vis_nxt),
    .nxt_win (h_sync_nxt)
  );

  vga_axis_counter #(
    .W(POS_W), .TOTAL(V_TOTAL), .VIS(V_VISIBLE), .WIN_LO(V_SS), .WIN_HI(V_SS + V_SYNC - 1)
  ) u_v (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (v_en),
    .wrap    (v_wrap),
    .count   (vga.vpos),
    .nxt_vis (v_vis_nxt),
    .nxt_win (v_sync_nxt)
  );

  // Decodes come from next-state values so they describe the position shown in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga.visible     <= 1'b0;
      vga.hsync       <= ~SYNC_POL;
      vga.vsync       <= ~SYNC_POL;
      vga.line_start  <= 1'b0;
      vga.frame_start <= 1'b0;
    end else begin
      vga.visible     <= h_vis_nxt & v_vis_nxt;
      vga.hsync       <= sync_level(SYNC_POL, h_sync_nxt);
      vga.vsync       <= sync_level(SYNC_POL, v_sync_nxt);
      vga.line_start  <= h_wrap;
      vga.frame_start <= v_wrap;
    end
  end

`ifdef VGA_FRAME_COUNTER_EN
  always_ff @(posedge clk) begin
    if (!rst_n)      vga.frame_cnt <= FRAME_W'(0);
    else if (v_wrap) vga.frame_cnt <= vga.frame_cnt + FRAME_W'(1);
  end
`else
  assign vga.frame_cnt = FRAME_W'(0);
`endif
endmodule
